// File: rtl/keypad_pkg.sv
// Shared key-code constants, state encoding and code width for the keypad entry block.
package keypad_pkg;

   localparam int CODE_W = 14;

   localparam logic [3:0] KEY_CLEAR = 4'hA;
   localparam logic [3:0] KEY_ENTER = 4'hB;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_COLLECT = 2'd1,
      ST_FULL    = 2'd2
   } state_t;

endpackage

// File: rtl/keypad_entry_timer.sv
// Inactivity timer: counts clocks while run is high, restarts on clear, flags the last cycle.
module keypad_entry_timer #(
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic run,
   output logic expired
);

   localparam logic [15:0] LAST = 16'(TIMEOUT_CYCLES - 1);

   logic [15:0] count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (clear || !run) begin
         count <= '0;
      end else if (count != LAST) begin
         count <= count + 16'd1;
      end
   end

   // Asserted during the TIMEOUT_CYCLES-th idle clock so the owner can act on that edge.
   assign expired = run && (count == LAST);

endmodule

// File: rtl/keypad_code_entry.sv
// Keypad code entry: collects NUM_DIGITS decimal digits and submits them on ENTER.
// Define KEYPAD_TIMEOUT_EN to discard partial entries after TIMEOUT_CYCLES idle clocks.
module keypad_code_entry
   import keypad_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int TIMEOUT_CYCLES = 1000
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              key_valid,
   input  logic [3:0]        key_code,
   output logic [CODE_W-1:0] code,
   output logic              code_valid,
   output logic [2:0]        digit_count,
   output logic              entry_err,
   output logic              timeout
);

   state_t            state;
   logic [CODE_W-1:0] acc;
   logic              expired;
   logic              timer_run;

   function automatic logic is_digit(input logic [3:0] k);
      return k <= 4'd9;
   endfunction

   // At most four digits, so the result never exceeds 9999 and fits CODE_W.
   function automatic logic [CODE_W-1:0] push_digit(input logic [CODE_W-1:0] a,
                                                     input logic [3:0]        d);
      return CODE_W'(a * CODE_W'(10)) + CODE_W'(d);
   endfunction

   assign timer_run = (state != ST_IDLE);

`ifdef KEYPAD_TIMEOUT_EN
   keypad_entry_timer #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (key_valid),
      .run     (timer_run),
      .expired (expired)
   );
`else
   // Constant 0 over the legal TIMEOUT_CYCLES range; no timer is built.
   assign expired = (TIMEOUT_CYCLES == 0);
`endif

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state       <= ST_IDLE;
         acc         <= '0;
         code        <= '0;
         digit_count <= '0;
         code_valid  <= 1'b0;
         entry_err   <= 1'b0;
         timeout     <= 1'b0;
      end else begin
         code_valid <= 1'b0;
         entry_err  <= 1'b0;
         timeout    <= 1'b0;
         if (key_valid) begin
            if (is_digit(key_code)) begin
               if (state == ST_FULL) begin
                  entry_err <= 1'b1;
               end else begin
                  acc         <= push_digit(acc, key_code);
                  digit_count <= digit_count + 3'd1;
                  state       <= ((digit_count + 3'd1) == 3'(NUM_DIGITS)) ? ST_FULL : ST_COLLECT;
               end
            end else if (key_code == KEY_ENTER) begin
               if (state == ST_FULL) begin
                  code       <= acc;
                  code_valid <= 1'b1;
               end else begin
                  entry_err <= 1'b1;
               end
               acc         <= '0;
               digit_count <= '0;
               state       <= ST_IDLE;
            end else if (key_code == KEY_CLEAR) begin
               acc         <= '0;
               digit_count <= '0;
               state       <= ST_IDLE;
            end else begin
               entry_err <= 1'b1;
            end
         end else if (expired) begin
            // A key on the expiry cycle takes the branch above and so beats the timeout.
            acc         <= '0;
            digit_count <= '0;
            state       <= ST_IDLE;
            timeout     <= 1'b1;
         end
      end
   end

endmodule

// File: doc/keypad_code_entry.md
KEYPAD_CODE_ENTRY -- requirements
Module: keypad_code_entry

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4, digits per code; legal range 1..4.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000, idle clocks before a partial entry is discarded; legal range 2..65535.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port key_valid  input  1  one-cycle strobe, key_code valid.
REQ-006 SHALL have port key_code  input  4  0x0-0x9 digit, 0xA CLEAR, 0xB ENTER, 0xC-0xF illegal.
REQ-007 SHALL have port code  output  14  last submitted code, binary value of the decimal digits.
REQ-008 SHALL have port code_valid  output  1  one-cycle pulse, code updated; feeds the lock's comparator.
REQ-009 SHALL have port digit_count  output  3  digits held in the current entry.
REQ-010 SHALL have port entry_err  output  1  one-cycle error pulse.
REQ-011 SHALL have port timeout  output  1  one-cycle pulse, partial entry discarded on inactivity.

Function
REQ-012 SHALL implement states IDLE (0 digits), COLLECT (1..NUM_DIGITS-1 digits), FULL (NUM_DIGITS digits).
REQ-013 SHALL register all outputs; a key strobe at edge N drives its response at edge N+1 (one-cycle latency).
REQ-014 Digit in IDLE/COLLECT: acc = acc*10 + digit, in 14 bits (max 9999, no overflow); digit_count+1; go to FULL when count reaches NUM_DIGITS, else COLLECT.
REQ-015 Digit in FULL: digit ignored, acc and count unchanged, entry_err pulses.
REQ-016 ENTER in FULL: code <= acc, code_valid pulses, acc and count cleared, go to IDLE.
REQ-017 ENTER in IDLE/COLLECT: entry_err pulses, acc and count cleared, go to IDLE, code unchanged.
REQ-018 CLEAR in any state: acc and count cleared, go to IDLE, no pulse.
REQ-019 Illegal code 0xC-0xF: entry_err pulses, state, acc and count unchanged.
REQ-020 code SHALL hold its value between submissions; code_valid is never asserted on consecutive cycles without a new ENTER.
REQ-021 No backpressure: a key arriving while code_valid is high SHALL be processed normally.
REQ-022 Leading zero digits SHALL count toward NUM_DIGITS (entry 0,0,4,2 gives code 42).

Reset
REQ-023 Reset SHALL asynchronously force IDLE, with acc, code, digit_count and the inactivity timer at 0.
REQ-024 Reset SHALL asynchronously force code_valid, entry_err and timeout to 0.
REQ-025 A key_valid coincident with reset SHALL be dropped; a partial entry interrupted by reset SHALL be lost.

Configuration
REQ-026 With KEYPAD_TIMEOUT_EN defined: a 16-bit timer runs in COLLECT/FULL and restarts on every key_valid; after TIMEOUT_CYCLES clocks without a key it clears acc and count, goes to IDLE and pulses timeout.
REQ-027 With KEYPAD_TIMEOUT_EN defined: a key arriving on the expiry cycle wins, is processed and restarts the timer, with no timeout pulse.
REQ-028 Without KEYPAD_TIMEOUT_EN: no timer is built, timeout is tied 0, and partial entries persist indefinitely.

Structure
REQ-029 Package keypad_pkg SHALL hold the key-code constants (KEY_CLEAR=4'hA, KEY_ENTER=4'hB), the state encoding and the code width (14).
REQ-030 The inactivity timer SHALL be sub-module keypad_entry_timer (inputs: clear, run; output: expired), instantiated only under KEYPAD_TIMEOUT_EN.

Verification
REQ-031 Keys 1,2,3,4,ENTER -> code=1234 with code_valid high for one cycle, one clock after ENTER; digit_count back to 0.
REQ-032 Keys 5,6,ENTER -> entry_err pulse, code unchanged, digit_count=0, no code_valid.
REQ-033 Keys 1,2,3,4,9 -> entry_err on the 9; then ENTER -> code=1234.
REQ-034 Keys 7,CLEAR,0,0,4,2,ENTER -> code=42, no entry_err; key 0xE mid-entry -> entry_err, digit_count unchanged.
REQ-035 Under KEYPAD_TIMEOUT_EN with TIMEOUT_CYCLES=10: key 3, then 10 idle clocks -> timeout pulse, digit_count=0.
REQ-036 Under KEYPAD_TIMEOUT_EN with TIMEOUT_CYCLES=10: key 3, then a key exactly on the expiry cycle -> no timeout, digit_count=2.
REQ-037 Reset asserted after 2 digits -> all outputs 0 asynchronously; after release, 9,9,9,9,ENTER -> code=9999.
